// File: rtl/mc_arb_pkg.sv
// Shared types and defaults for the LPDDR2 controller port arbiter.
// The tag records which client issued a read and how many beats it expects back.
package mc_arb_pkg;

    localparam int NPORTS_DEF     = 4;
    localparam int ADDR_W_DEF     = 25;
    localparam int DATA_W_DEF     = 128;
    localparam int SIZE_W_DEF     = 5;
    localparam int RTAG_DEPTH_DEF = 16;
    localparam int PORT_W_DEF     = $clog2(NPORTS_DEF);

    typedef struct packed {
        logic [PORT_W_DEF-1:0] port;
        logic [SIZE_W_DEF-1:0] size;
    } tag_t;

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } arb_state_t;

    function automatic int tag_width(input int nports, input int size_w);
        return $clog2(nports) + size_w;
    endfunction

endpackage

// File: rtl/mc_arb_tagfifo.sv
// Synchronous FIFO holding read tags in issue order; head is visible without a pop.
module mc_arb_tagfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = push && !full;
    assign do_rd = pop && !empty;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mc_port_arb.sv
// Round-robin merge of N Avalon-MM clients onto the single LPDDR2 controller port,
// with write-burst grant locking and tag-FIFO steering of returned read beats.
module mc_port_arb
    import mc_arb_pkg::*;
#(
    parameter int NPORTS     = NPORTS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BE_W       = DATA_W / 8,
    parameter int SIZE_W     = SIZE_W_DEF,
    parameter int RTAG_DEPTH = RTAG_DEPTH_DEF
) (
    input  logic                     clkrst_avl_clk,
    input  logic                     clkrst_avl_rst_n,
    input  logic                     mc_ready,
    input  logic [NPORTS*ADDR_W-1:0] cli_addr,
    input  logic [NPORTS*BE_W-1:0]   cli_be,
    input  logic [NPORTS*DATA_W-1:0] cli_wdata,
    input  logic [NPORTS*SIZE_W-1:0] cli_size,
    input  logic [NPORTS-1:0]        cli_burstbegin,
    input  logic [NPORTS-1:0]        cli_read_req,
    input  logic [NPORTS-1:0]        cli_write_req,
    output logic [NPORTS-1:0]        cli_ready,
    output logic [DATA_W-1:0]        cli_rdata,
    output logic [NPORTS-1:0]        cli_rdata_valid,
    output logic [ADDR_W-1:0]        arb2mc_avl_addr_0,
    output logic [BE_W-1:0]          arb2mc_avl_be_0,
    output logic [DATA_W-1:0]        arb2mc_avl_wdata_0,
    output logic [SIZE_W-1:0]        arb2mc_avl_size_0,
    output logic                     arb2mc_avl_burstbegin_0,
    output logic                     arb2mc_avl_read_req_0,
    output logic                     arb2mc_avl_write_req_0,
    input  logic                     arb2mc_avl_ready_0,
    input  logic [DATA_W-1:0]        arb2mc_avl_rdata_0,
    input  logic                     arb2mc_avl_rdata_valid_0,
    output logic                     err_unexp_rdata
);

    localparam int PORT_W = $clog2(NPORTS);
    localparam int TAG_W  = tag_width(NPORTS, SIZE_W);
    localparam int CNT_W  = $clog2(RTAG_DEPTH) + 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [SIZE_W-1:0] size;
    } rtag_t;

    arb_state_t        state_q, state_d;
    logic [PORT_W-1:0] rr_q, rr_d;
    logic [PORT_W-1:0] lock_q, lock_d;
    logic [SIZE_W-1:0] wcnt_q, wcnt_d;
    logic [SIZE_W-1:0] rcnt_q;
    logic [PORT_W-1:0] gnt;
    logic              gnt_valid, gnt_rd, gnt_wr, accept;
    logic [NPORTS-1:0] eligible;
    logic              read_ok;
    rtag_t             push_tag, head_tag;
    logic              fifo_full, fifo_empty, push, pop, rd_hit;
    logic [CNT_W-1:0]  fifo_count;

    function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
        return (s == '0) ? SIZE_W'(1) : s;
    endfunction

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(NPORTS-1)) ? '0 : p + PORT_W'(1);
    endfunction

    assign read_ok = (fifo_count < CNT_W'(RTAG_DEPTH));

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORTS; i++) begin
            eligible[i] = cli_burstbegin[i] && (cli_write_req[i] || (cli_read_req[i] && read_ok));
        end
    end

    // Scan downward from rr+NPORTS-1 so the candidate nearest rr is the last to win.
    // Outputs are forced off during reset so the controller sees nothing mid-reset.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        if (clkrst_avl_rst_n) begin
            if (state_q == WBURST) begin
                gnt       = lock_q;
                gnt_valid = 1'b1;
                gnt_wr    = cli_write_req[lock_q];
            end else if (mc_ready) begin
                for (int k = NPORTS - 1; k >= 0; k--) begin
                    if (eligible[(int'(rr_q) + k) % NPORTS]) begin
                        gnt       = PORT_W'((int'(rr_q) + k) % NPORTS);
                        gnt_valid = 1'b1;
                    end
                end
                gnt_wr = gnt_valid && cli_write_req[gnt];
                gnt_rd = gnt_valid && !cli_write_req[gnt] && cli_read_req[gnt];
            end
        end
    end

    assign accept    = (gnt_rd || gnt_wr) && arb2mc_avl_ready_0;
    assign cli_ready = accept ? (NPORTS'(1) << gnt) : '0;

    always_comb begin
        arb2mc_avl_addr_0       = '0;
        arb2mc_avl_be_0         = '0;
        arb2mc_avl_wdata_0      = '0;
        arb2mc_avl_size_0       = '0;
        arb2mc_avl_burstbegin_0 = 1'b0;
        arb2mc_avl_read_req_0   = 1'b0;
        arb2mc_avl_write_req_0  = 1'b0;
        if (gnt_valid) begin
            arb2mc_avl_addr_0       = cli_addr[int'(gnt)*ADDR_W +: ADDR_W];
            arb2mc_avl_be_0         = cli_be[int'(gnt)*BE_W +: BE_W];
            arb2mc_avl_wdata_0      = cli_wdata[int'(gnt)*DATA_W +: DATA_W];
            arb2mc_avl_size_0       = cli_size[int'(gnt)*SIZE_W +: SIZE_W];
            arb2mc_avl_burstbegin_0 = cli_burstbegin[gnt];
            arb2mc_avl_read_req_0   = gnt_rd;
            arb2mc_avl_write_req_0  = gnt_wr;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (gnt_rd || eff_size(arb2mc_avl_size_0) == SIZE_W'(1)) begin
                        rr_d = next_port(gnt);
                    end else begin
                        lock_d  = gnt;
                        wcnt_d  = eff_size(arb2mc_avl_size_0) - SIZE_W'(1);
                        state_d = WBURST;
                    end
                end
            end
            WBURST: begin
                if (accept) begin
                    wcnt_d = wcnt_q - SIZE_W'(1);
                    if (wcnt_q == SIZE_W'(1)) begin
                        rr_d    = next_port(lock_q);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_tag = '{port: gnt, size: arb2mc_avl_size_0};
    assign push     = accept && gnt_rd && !fifo_full;

    // rcnt counts beats already returned for the head tag; the last one pops it.
    assign rd_hit          = clkrst_avl_rst_n && arb2mc_avl_rdata_valid_0 && !fifo_empty;
    assign pop             = rd_hit && (rcnt_q == eff_size(head_tag.size) - SIZE_W'(1));
    assign cli_rdata_valid = rd_hit ? (NPORTS'(1) << head_tag.port) : '0;
    assign cli_rdata       = arb2mc_avl_rdata_0;

    mc_arb_tagfifo #(
        .W     (TAG_W),
        .DEPTH (RTAG_DEPTH)
    ) u_tagfifo (
        .clk   (clkrst_avl_clk),
        .rst_n (clkrst_avl_rst_n),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clkrst_avl_clk or negedge clkrst_avl_rst_n) begin
        if (!clkrst_avl_rst_n) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            lock_q          <= '0;
            wcnt_q          <= '0;
            rcnt_q          <= '0;
            err_unexp_rdata <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            wcnt_q  <= wcnt_d;
            if (pop) begin
                rcnt_q <= '0;
            end else if (rd_hit) begin
                rcnt_q <= rcnt_q + SIZE_W'(1);
            end
            if (arb2mc_avl_rdata_valid_0 && fifo_empty) begin
                err_unexp_rdata <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_port_arb.sv
// Directed and randomized bench for mc_port_arb against a queue-based model of
// the arbitration and read-return rules.
module tb_mc_port_arb;

    localparam int NP    = 4;
    localparam int AW    = 25;
    localparam int DW    = 128;
    localparam int BW    = DW / 8;
    localparam int SW    = 5;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mc_ready = 1'b0;
    logic [NP*AW-1:0]  cli_addr = '0;
    logic [NP*BW-1:0]  cli_be = '0;
    logic [NP*DW-1:0]  cli_wdata = '0;
    logic [NP*SW-1:0]  cli_size = '0;
    logic [NP-1:0]     cli_burstbegin = '0;
    logic [NP-1:0]     cli_read_req = '0;
    logic [NP-1:0]     cli_write_req = '0;
    logic [NP-1:0]     cli_ready;
    logic [DW-1:0]     cli_rdata;
    logic [NP-1:0]     cli_rdata_valid;
    logic [AW-1:0]     avl_addr;
    logic [BW-1:0]     avl_be;
    logic [DW-1:0]     avl_wdata;
    logic [SW-1:0]     avl_size;
    logic              avl_burstbegin, avl_read_req, avl_write_req;
    logic              avl_ready = 1'b0;
    logic [DW-1:0]     avl_rdata = '0;
    logic              avl_rdata_valid = 1'b0;
    logic              err;

    always #5 clk = ~clk;

    mc_port_arb #(
        .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .RTAG_DEPTH(DEPTH)
    ) dut (
        .clkrst_avl_clk           (clk),
        .clkrst_avl_rst_n         (rst_n),
        .mc_ready                 (mc_ready),
        .cli_addr                 (cli_addr),
        .cli_be                   (cli_be),
        .cli_wdata                (cli_wdata),
        .cli_size                 (cli_size),
        .cli_burstbegin           (cli_burstbegin),
        .cli_read_req             (cli_read_req),
        .cli_write_req            (cli_write_req),
        .cli_ready                (cli_ready),
        .cli_rdata                (cli_rdata),
        .cli_rdata_valid          (cli_rdata_valid),
        .arb2mc_avl_addr_0        (avl_addr),
        .arb2mc_avl_be_0          (avl_be),
        .arb2mc_avl_wdata_0       (avl_wdata),
        .arb2mc_avl_size_0        (avl_size),
        .arb2mc_avl_burstbegin_0  (avl_burstbegin),
        .arb2mc_avl_read_req_0    (avl_read_req),
        .arb2mc_avl_write_req_0   (avl_write_req),
        .arb2mc_avl_ready_0       (avl_ready),
        .arb2mc_avl_rdata_0       (avl_rdata),
        .arb2mc_avl_rdata_valid_0 (avl_rdata_valid),
        .err_unexp_rdata          (err)
    );

    int total = 0;
    int bad = 0;

    // Reference model: round-robin pointer, lock owner with beats left, and a tag queue.
    int rr_m, lock_m, rem_m, hdone;
    bit err_m;
    int qport[$];
    int qsize[$];
    int wr_left[NP];

    function automatic int effs(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s observed=timeout expected=completion", tag);
    endtask

    task automatic model_reset();
        rr_m = 0; lock_m = 0; rem_m = 0; hdone = 0; err_m = 0;
        qport.delete();
        qsize.delete();
    endtask

    task automatic clear_clients();
        cli_read_req = '0;
        cli_write_req = '0;
        cli_burstbegin = '0;
        for (int p = 0; p < NP; p++) wr_left[p] = 0;
    endtask

    task automatic issue_read(input int p, input int sz);
        cli_addr[p*AW +: AW] = AW'($urandom);
        cli_size[p*SW +: SW] = SW'(sz);
        cli_read_req[p] = 1'b1;
        cli_burstbegin[p] = 1'b1;
    endtask

    task automatic issue_write(input int p, input int sz);
        cli_addr[p*AW +: AW] = AW'($urandom);
        cli_be[p*BW +: BW] = BW'($urandom);
        cli_wdata[p*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        cli_size[p*SW +: SW] = SW'(sz);
        cli_write_req[p] = 1'b1;
        cli_burstbegin[p] = 1'b1;
        wr_left[p] = effs(sz);
    endtask

    // One clock: compare the DUT's combinational view against the model, then advance both.
    task automatic cycle();
        int g, gi, sz;
        bit grd, gwr, acc, rv;
        logic [NP-1:0] exp_ready, exp_rv;
        #2;
        g = -1; grd = 0; gwr = 0;
        if (rst_n) begin
            if (rem_m > 0) begin
                g = lock_m;
                gwr = cli_write_req[g];
            end else if (mc_ready) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (rr_m + k) % NP;
                    if (g < 0 && cli_burstbegin[p] &&
                        (cli_write_req[p] || (cli_read_req[p] && qport.size() < DEPTH))) g = p;
                end
                if (g >= 0) begin
                    gwr = cli_write_req[g];
                    grd = !cli_write_req[g];
                end
            end
        end
        gi = (g < 0) ? 0 : g;
        acc = (grd || gwr) && avl_ready;
        rv = avl_rdata_valid;
        exp_ready = acc ? (NP'(1) << gi) : '0;
        exp_rv = (rst_n && rv && qport.size() > 0) ? (NP'(1) << qport[0]) : '0;
        sz = effs(int'(cli_size[gi*SW +: SW]));
        chk("cli_ready", cli_ready, exp_ready);
        chk("avl_read_req", avl_read_req, grd);
        chk("avl_write_req", avl_write_req, gwr);
        chk("avl_addr", avl_addr, (g >= 0) ? cli_addr[gi*AW +: AW] : '0);
        chk("avl_size", avl_size, (g >= 0) ? cli_size[gi*SW +: SW] : '0);
        chk("rdata_valid", cli_rdata_valid, exp_rv);
        if (exp_rv != '0) chk("rdata", cli_rdata, avl_rdata);
        chk("err_unexp_rdata", err, err_m);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (rv) begin
                if (qport.size() == 0) err_m = 1;
                else begin
                    hdone++;
                    if (hdone >= qsize[0]) begin
                        void'(qport.pop_front());
                        void'(qsize.pop_front());
                        hdone = 0;
                    end
                end
            end
            if (acc) begin
                if (rem_m > 0) begin
                    rem_m--;
                    if (rem_m == 0) rr_m = (lock_m + 1) % NP;
                end else if (grd) begin
                    qport.push_back(g);
                    qsize.push_back(sz);
                    rr_m = (g + 1) % NP;
                end else if (sz == 1) begin
                    rr_m = (g + 1) % NP;
                end else begin
                    lock_m = g;
                    rem_m = sz - 1;
                end
                cli_burstbegin[g] = 1'b0;
                if (grd) cli_read_req[g] = 1'b0;
                else begin
                    wr_left[g]--;
                    if (wr_left[g] <= 0) cli_write_req[g] = 1'b0;
                    cli_wdata[g*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_clients();
        avl_rdata_valid = 1'b0;
        #1;
        model_reset();
        chk("rst_cli_ready", cli_ready, '0);
        chk("rst_rdata_valid", cli_rdata_valid, '0);
        chk("rst_err", err, 1'b0);
        chk("rst_avl_req", {avl_read_req, avl_write_req}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int issued, beats, seen, seen2;
        bit done;
        model_reset();
        clear_clients();
        do_reset();

        $display("[TB] four simultaneous single reads");
        mc_ready = 1'b1;
        avl_ready = 1'b1;
        for (int p = 0; p < NP; p++) issue_read(p, 1);
        for (int i = 0; i < NP; i++) begin
            #2;
            chk("t1_grant_order", cli_ready, NP'(1) << i);
            cycle();
        end
        avl_rdata_valid = 1'b1;
        for (int i = 0; i < NP; i++) begin
            avl_rdata = {$urandom, $urandom, $urandom, $urandom};
            #2;
            chk("t1_return_order", cli_rdata_valid, NP'(1) << i);
            cycle();
        end
        avl_rdata_valid = 1'b0;

        $display("[TB] write burst lock with toggling ready");
        issue_write(2, 4);
        cycle();
        issue_read(1, 1);
        for (int i = 0; i < 6; i++) begin
            avl_ready = (i % 2 == 1);
            cycle();
        end
        avl_ready = 1'b1;
        #2;
        chk("t2_client1_after_burst", cli_ready, 4'b0010);
        cycle();

        $display("[TB] tag fifo full stall");
        do_reset();
        issued = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!cli_read_req[p] && issued < DEPTH + 1) begin
                    issue_read(p, 1);
                    issued++;
                end
            end
            if (issued == DEPTH + 1 && qport.size() == DEPTH) done = 1;
            else cycle();
        end
        if (!done) bound_fail("t3_fill");
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t3_full_stall", cli_ready, '0);
            cycle();
        end
        avl_rdata_valid = 1'b1;
        avl_rdata = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        avl_rdata_valid = 1'b0;
        #2;
        chk("t3_resume_after_pop", |cli_ready, 1'b1);
        cycle();

        $display("[TB] eight-beat read return interleaved with writes");
        do_reset();
        issue_read(3, 8);
        cycle();
        beats = 0;
        seen = 0;
        for (int i = 0; i < 30 && beats < 8; i++) begin
            if (!cli_write_req[0]) issue_write(0, 1);
            avl_rdata_valid = (i % 2 == 0);
            avl_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (avl_rdata_valid) beats++;
            #2;
            if (cli_rdata_valid === 4'b1000) seen++;
            cycle();
        end
        chk("t4_beat_count", seen, 8);
        avl_rdata_valid = 1'b1;
        cycle();
        avl_rdata_valid = 1'b0;
        #2;
        chk("t4_head_popped", err, 1'b1);
        cycle();

        $display("[TB] mc_ready gating");
        do_reset();
        mc_ready = 1'b0;
        issue_read(0, 1);
        issue_write(1, 1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t5_rd_blocked", avl_read_req, 1'b0);
            chk("t5_wr_blocked", avl_write_req, 1'b0);
            cycle();
        end
        mc_ready = 1'b1;
        repeat (2) cycle();
        issue_write(2, 4);
        cycle();
        mc_ready = 1'b0;
        seen2 = 0;
        for (int i = 0; i < 10 && rem_m > 0; i++) begin
            #2;
            if (cli_ready === 4'b0100) seen2++;
            cycle();
        end
        if (rem_m > 0) bound_fail("t5_burst");
        chk("t5_burst_beats_without_mc_ready", seen2, 3);
        mc_ready = 1'b1;

        $display("[TB] unexpected read data and async reset mid-burst");
        do_reset();
        avl_rdata_valid = 1'b1;
        cycle();
        avl_rdata_valid = 1'b0;
        cycle();
        #2;
        chk("t6_err_sticky", err, 1'b1);
        cycle();
        issue_write(1, 6);
        repeat (2) cycle();
        rst_n = 1'b0;
        avl_rdata_valid = 1'b1;
        #1;
        chk("t6_rst_cli_ready", cli_ready, '0);
        chk("t6_rst_write_req", avl_write_req, 1'b0);
        chk("t6_rst_rdata_valid", cli_rdata_valid, '0);
        chk("t6_rst_err", err, 1'b0);
        do_reset();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            mc_ready = ($urandom % 8) != 0;
            avl_ready = ($urandom % 4) != 0;
            for (int p = 0; p < NP; p++) begin
                if (!cli_read_req[p] && !cli_write_req[p] && ($urandom % 4) == 0) begin
                    if ($urandom % 2) issue_read(p, $urandom_range(0, 6));
                    else issue_write(p, $urandom_range(0, 6));
                end
            end
            avl_rdata_valid = (qport.size() > 0) && (($urandom % 3) == 0);
            avl_rdata = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        avl_rdata_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
